// File: rtl/async_fifo_rd_stream.sv
// Read-side adapter: turns the FIFO's registered-read port into a valid/ready stream.
// Optional ASYNC_FIFO_RD_STREAM_STATS_EN adds the rd_cnt_o transfer counter and the stall_o flag.
module async_fifo_rd_stream #(
    parameter int DATA_WIDTH = 8,
    parameter int BUF_DEPTH  = 3
) (
    input  logic                  clkb_i,
    input  logic                  rrst_ni,
    input  logic                  en_i,
    input  logic                  fifo_rrdy_i,
    output logic                  fifo_reb_o,
    input  logic [DATA_WIDTH-1:0] fifo_doutb_i,
    output logic                  m_valid_o,
    input  logic                  m_ready_i,
    output logic [DATA_WIDTH-1:0] m_data_o,
    output logic                  busy_o
`ifdef ASYNC_FIFO_RD_STREAM_STATS_EN
    ,
    output logic [15:0]           rd_cnt_o,
    output logic                  stall_o
`endif
);
    localparam int CNT_W = $clog2(BUF_DEPTH + 1);
    localparam int PTR_W = $clog2(BUF_DEPTH);
    localparam logic [CNT_W:0]   DEPTH_OCC = (CNT_W + 1)'(BUF_DEPTH);
    localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(BUF_DEPTH - 1);

    logic [DATA_WIDTH-1:0] buf_mem [BUF_DEPTH];
    logic [PTR_W-1:0]      head_q;
    logic [PTR_W-1:0]      tail_q;
    logic [CNT_W-1:0]      count_q;
    logic                  pend_q;
    logic [CNT_W:0]        occ;
    logic                  pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    // Occupancy includes the word still in flight so a read is only issued with a free slot.
    assign occ        = {1'b0, count_q} + {{CNT_W{1'b0}}, pend_q};
    assign fifo_reb_o = en_i && fifo_rrdy_i && (occ < DEPTH_OCC);
    assign m_valid_o  = (count_q != '0);
    assign m_data_o   = buf_mem[head_q];
    assign pop        = m_valid_o && m_ready_i;
    assign busy_o     = pend_q || m_valid_o;

    always_ff @(posedge clkb_i or negedge rrst_ni) begin
        if (!rrst_ni) begin
            pend_q  <= 1'b0;
            count_q <= '0;
            head_q  <= '0;
            tail_q  <= '0;
        end else begin
            pend_q <= fifo_reb_o;
            if (pend_q) tail_q <= ptr_inc(tail_q);
            if (pop)    head_q <= ptr_inc(head_q);
            if (pend_q && !pop)      count_q <= count_q + 1'b1;
            else if (!pend_q && pop) count_q <= count_q - 1'b1;
        end
    end

    // Storage is data only; it is never reset.
    always_ff @(posedge clkb_i) begin
        if (pend_q) buf_mem[tail_q] <= fifo_doutb_i;
    end

`ifndef SYNTHESIS
    credit_never_exceeded: assert property (@(posedge clkb_i) disable iff (!rrst_ni)
        occ <= DEPTH_OCC);
`endif

`ifdef ASYNC_FIFO_RD_STREAM_STATS_EN
    always_ff @(posedge clkb_i or negedge rrst_ni) begin
        if (!rrst_ni)  rd_cnt_o <= '0;
        else if (pop)  rd_cnt_o <= rd_cnt_o + 16'd1;
    end

    assign stall_o = en_i && fifo_rrdy_i && !fifo_reb_o;
`endif
endmodule

// File: tb/tb_async_fifo_rd_stream.sv
// Bench for async_fifo_rd_stream: queue-level reference model plus directed scenarios.
module tb_async_fifo_rd_stream;
    localparam int DW = 8;
    localparam int D  = 3;

    logic          clkb_i = 1'b0;
    logic          rrst_ni = 1'b0;
    logic          en_i = 1'b0;
    logic          m_ready_i = 1'b0;
    logic          rrdy_en = 1'b0;
    logic          fifo_rrdy_i;
    logic          fifo_reb_o;
    logic          m_valid_o;
    logic          busy_o;
    logic [DW-1:0] fifo_doutb_i = '0;
    logic [DW-1:0] m_data_o;
`ifdef ASYNC_FIFO_RD_STREAM_STATS_EN
    logic [15:0]   rd_cnt_o;
    logic          stall_o;
`endif

    logic [DW-1:0] src_mem [256];
    int            src_wr = 0;
    int            src_rd = 0;
    int            total = 0;
    int            bad = 0;
    logic [DW-1:0] mq[$];
    logic          m_pend = 1'b0;
    logic [DW-1:0] m_pend_w = '0;
    int            m_rd = 0;
    logic [DW-1:0] dut_log[$];

    async_fifo_rd_stream #(.DATA_WIDTH(DW), .BUF_DEPTH(D)) dut (
        .clkb_i      (clkb_i),
        .rrst_ni     (rrst_ni),
        .en_i        (en_i),
        .fifo_rrdy_i (fifo_rrdy_i),
        .fifo_reb_o  (fifo_reb_o),
        .fifo_doutb_i(fifo_doutb_i),
        .m_valid_o   (m_valid_o),
        .m_ready_i   (m_ready_i),
        .m_data_o    (m_data_o),
        .busy_o      (busy_o)
`ifdef ASYNC_FIFO_RD_STREAM_STATS_EN
        ,
        .rd_cnt_o    (rd_cnt_o),
        .stall_o     (stall_o)
`endif
    );

    always #5 clkb_i = ~clkb_i;

    // FIFO read side: registered read data, contents flushed by its reset.
    assign fifo_rrdy_i = rrdy_en && (src_rd < src_wr);
    always @(posedge clkb_i or negedge rrst_ni) begin
        if (!rrst_ni) begin
            src_rd <= src_wr;
        end else if (fifo_reb_o) begin
            fifo_doutb_i <= src_mem[src_rd[7:0]];
            src_rd       <= src_rd + 1;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [DW-1:0] w);
        src_mem[src_wr[7:0]] = w;
        src_wr++;
    endtask

    task automatic next_cycle();
        @(posedge clkb_i);
        #1;
    endtask

    // Reference model: words in the buffer as a queue, one word may be in flight.
    initial forever begin
        logic reb_e;
        @(negedge clkb_i);
        if (!rrst_ni) begin
            mq.delete();
            m_pend = 1'b0;
            m_rd   = src_wr;
        end
        reb_e = en_i && fifo_rrdy_i && ((mq.size() + int'(m_pend)) < D);
        check("reb", {31'd0, fifo_reb_o}, {31'd0, reb_e});
        check("m_valid", {31'd0, m_valid_o}, {31'd0, mq.size() != 0});
        check("busy", {31'd0, busy_o}, {31'd0, m_pend || (mq.size() != 0)});
        if (mq.size() != 0) check("m_data", {24'd0, m_data_o}, {24'd0, mq[0]});
`ifdef ASYNC_FIFO_RD_STREAM_STATS_EN
        check("stall", {31'd0, stall_o}, {31'd0, en_i && fifo_rrdy_i && !reb_e});
`endif
        if (m_valid_o && m_ready_i) dut_log.push_back(m_data_o);
        if (rrst_ni) begin
            if (mq.size() != 0 && m_ready_i) void'(mq.pop_front());
            if (m_pend) mq.push_back(m_pend_w);
            m_pend = reb_e;
            if (reb_e) begin
                m_pend_w = src_mem[m_rd[7:0]];
                m_rd++;
            end
        end
    end

    initial begin
        int nreb;
        int base;
        repeat (3) next_cycle();
        @(negedge clkb_i);
        check("rst_valid", {31'd0, m_valid_o}, 32'd0);
        check("rst_busy", {31'd0, busy_o}, 32'd0);
        check("rst_reb", {31'd0, fifo_reb_o}, 32'd0);
        next_cycle();
        rrst_ni = 1'b1;

        // Single word latency
        next_cycle();
        push(8'hA5); en_i = 1'b1; m_ready_i = 1'b1; rrdy_en = 1'b1;
        @(negedge clkb_i); check("t1_reb_c0", {31'd0, fifo_reb_o}, 32'd1);
        next_cycle(); @(negedge clkb_i); check("t1_valid_c1", {31'd0, m_valid_o}, 32'd0);
        next_cycle(); @(negedge clkb_i);
        check("t1_valid_c2", {31'd0, m_valid_o}, 32'd1);
        check("t1_data_c2", {24'd0, m_data_o}, 32'hA5);
        next_cycle(); @(negedge clkb_i);
        check("t1_valid_c3", {31'd0, m_valid_o}, 32'd0);
        check("t1_busy_c3", {31'd0, busy_o}, 32'd0);

        // Backpressure: only BUF_DEPTH reads, then in-order drain
        next_cycle();
        m_ready_i = 1'b0;
        for (int i = 1; i <= 5; i++) push(i[7:0]);
        nreb = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clkb_i);
            if (fifo_reb_o) nreb++;
            next_cycle();
        end
        check("t2_nreb", nreb, 32'd3);
        check("t2_data_head", {24'd0, m_data_o}, 32'h01);
        base = dut_log.size();
        m_ready_i = 1'b1;
        repeat (10) next_cycle();
        check("t2_count", dut_log.size(), base + 5);
        for (int k = 0; k < 5; k++)
            if (base + k < dut_log.size()) check("t2_order", {24'd0, dut_log[base+k]}, k + 1);

        // Sustained rate
        for (int i = 0; i < 20; i++) push(8'h40 + i[7:0]);
        for (int k = 1; k <= 16; k++) begin
            next_cycle(); @(negedge clkb_i);
            if (k >= 2) begin
                check("t3_valid", {31'd0, m_valid_o}, 32'd1);
                check("t3_reb", {31'd0, fifo_reb_o}, 32'd1);
            end
        end
        repeat (8) next_cycle();

        // en_i dropped on the accept edge
        push(8'h33); push(8'h44);
        @(negedge clkb_i); check("t4_reb_c0", {31'd0, fifo_reb_o}, 32'd1);
        next_cycle(); en_i = 1'b0;
        @(negedge clkb_i); check("t4_reb_c1", {31'd0, fifo_reb_o}, 32'd0);
        next_cycle(); @(negedge clkb_i);
        check("t4_valid_c2", {31'd0, m_valid_o}, 32'd1);
        check("t4_data_c2", {24'd0, m_data_o}, 32'h33);
        for (int k = 0; k < 3; k++) begin
            next_cycle(); @(negedge clkb_i);
            check("t4_reb_off", {31'd0, fifo_reb_o}, 32'd0);
        end
        next_cycle(); en_i = 1'b1;
        repeat (6) next_cycle();

        // Asynchronous reset with count=2, pend=1
        m_ready_i = 1'b0;
        for (int i = 0; i < 5; i++) push(8'h11 + i[7:0]);
        repeat (3) next_cycle();
        check("t5_valid_pre", {31'd0, m_valid_o}, 32'd1);
        #1 rrst_ni = 1'b0;
        #1;
        check("t5_valid_async", {31'd0, m_valid_o}, 32'd0);
        check("t5_busy_async", {31'd0, busy_o}, 32'd0);
        @(negedge clkb_i);
        #2 rrst_ni = 1'b1;
        next_cycle();
        push(8'h77); m_ready_i = 1'b1;
        base = dut_log.size();
        repeat (5) next_cycle();
        check("t5_count", dut_log.size(), base + 1);
        if (dut_log.size() > base) check("t5_first", {24'd0, dut_log[base]}, 32'h77);

`ifdef ASYNC_FIFO_RD_STREAM_STATS_EN
        rrst_ni = 1'b0;
        next_cycle();
        rrst_ni = 1'b1;
        dut_log.delete();
        for (int i = 0; i < 70000; i++) begin
            push(i[7:0]);
            next_cycle();
        end
        repeat (8) next_cycle();
        check("t6_rd_cnt", {16'd0, rd_cnt_o}, 32'd4464);
        m_ready_i = 1'b0;
        for (int i = 0; i < 5; i++) push(8'hC0 + i[7:0]);
        repeat (6) next_cycle();
        @(negedge clkb_i);
        check("t6_stall", {31'd0, stall_o}, 32'd1);
        check("t6_reb_full", {31'd0, fifo_reb_o}, 32'd0);
`endif

        repeat (2) next_cycle();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
